counter_sequencer: RTL and testbench

Round-robin scheduler that shares one `counter` instance between `NUM_REQ` requesters. Each requester submits a counting job: seed, direction, rate and target. The block grants jobs one at a time, then sequences the counter's init/growth/decay/clear controls until the count reaches the target, an overflow/underflow is imminent, or the job is aborted. It then returns the final count to the requester and clears the counter before the next grant. It sits between software-visible measurement/timeout clients and the shared `counter` datapath.

---
 rtl/counter_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_counter_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: round-robin scheduler that time-shares one up/down counter between requesters.
// Each granted job is loaded, stepped until target/wrap/abort, reported, then the counter is cleared.

module counter #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clk_en,
  input  logic                 srst,
  input  logic                 init_en,
  input  logic                 clear_en,
  input  logic                 counter_en,
  input  logic                 decay_en,
  input  logic [BIT_WIDTH-1:0] seed_i,
  input  logic [BIT_WIDTH-1:0] growth_rate_i,
  input  logic [BIT_WIDTH-1:0] decay_rate_i,
  output logic [BIT_WIDTH-1:0] count_o
);

  logic [BIT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (srst) begin
      count_d = '0;
    end else if (counter_en) begin
      if (clear_en)      count_d = '0;
      else if (init_en)  count_d = seed_i;
      else if (decay_en) count_d = count_q - decay_rate_i;
      else               count_d = count_q + growth_rate_i;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

module counter_sequencer #(
  parameter  int NUM_REQ   = 4,
  parameter  int BIT_WIDTH = 8,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_en,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0]             req_dir_i,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_seed_i,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_rate_i,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_target_i,
  input  logic                           abort_i,
  output logic                           done_valid_o,
  input  logic                           done_ready_i,
  output logic [ID_W-1:0]                done_id_o,
  output logic [BIT_WIDTH-1:0]           done_count_o,
  output logic                           done_err_o,
  output logic                           busy_o
);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_REPORT
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 dir_q, dir_d;
  logic [BIT_WIDTH-1:0] seed_q, seed_d;
  logic [BIT_WIDTH-1:0] rate_q, rate_d;
  logic [BIT_WIDTH-1:0] target_q, target_d;
  logic                 done_valid_q, done_valid_d;
  logic [BIT_WIDTH-1:0] done_count_q, done_count_d;
  logic                 done_err_q, done_err_d;

  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  int                   scan_idx;

  logic                 init_en, clear_en, counter_en, decay_en;
  logic [BIT_WIDTH-1:0] count;
  logic [BIT_WIDTH:0]   up_sum;
  logic                 target_hit, wrap_next;
  logic                 finish, finish_err;

  counter #(.BIT_WIDTH(BIT_WIDTH)) u_counter (
    .clk          (clk),
    .clk_en       (clk_en),
    .srst         (1'b0),
    .init_en      (init_en),
    .clear_en     (clear_en),
    .counter_en   (counter_en),
    .decay_en     (decay_en),
    .seed_i       (seed_q),
    .growth_rate_i(rate_q),
    .decay_rate_i (rate_q),
    .count_o      (count)
  );

  // Scan from the pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(scan_idx);
      end
    end
  end

  assign up_sum     = {1'b0, count} + {1'b0, rate_q};
  assign target_hit = dir_q ? (count <= target_q) : (count >= target_q);
  assign wrap_next  = dir_q ? (count < rate_q) : up_sum[BIT_WIDTH];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    dir_d        = dir_q;
    seed_d       = seed_q;
    rate_d       = rate_q;
    target_d     = target_q;
    done_valid_d = done_valid_q;
    done_count_d = done_count_q;
    done_err_d   = done_err_q;
    init_en      = 1'b0;
    clear_en     = 1'b0;
    counter_en   = 1'b0;
    decay_en     = 1'b0;
    finish       = 1'b0;
    finish_err   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clear_en   = 1'b1;
        counter_en = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_IDLE: begin
        if (grant_found) begin
          id_d     = grant_idx;
          dir_d    = req_dir_i[grant_idx];
          seed_d   = req_seed_i[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
          rate_d   = req_rate_i[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
          target_d = req_target_i[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        init_en    = 1'b1;
        counter_en = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (abort_i) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else if (target_hit) begin
          finish     = 1'b1;
        end else if (rate_q == '0 || wrap_next) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          counter_en = 1'b1;
          decay_en   = dir_q;
        end
        if (finish) begin
          state_d      = ST_REPORT;
          done_valid_d = 1'b1;
          done_count_d = count;
          done_err_d   = finish_err;
        end
      end
      ST_REPORT: begin
        // The pointer moves past the finished requester so the next grant starts after it.
        if (done_ready_i) begin
          done_valid_d = 1'b0;
          state_d      = ST_CLEAR;
          ptr_d        = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      ptr_q        <= '0;
      id_q         <= '0;
      dir_q        <= 1'b0;
      seed_q       <= '0;
      rate_q       <= '0;
      target_q     <= '0;
      done_valid_q <= 1'b0;
      done_count_q <= '0;
      done_err_q   <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      dir_q        <= dir_d;
      seed_q       <= seed_d;
      rate_q       <= rate_d;
      target_q     <= target_d;
      done_valid_q <= done_valid_d;
      done_count_q <= done_count_d;
      done_err_q   <= done_err_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign done_valid_o = done_valid_q;
  assign done_id_o    = id_q;
  assign done_count_o = done_count_q;
  assign done_err_o   = done_err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed and random jobs; expected results come from a
// rule-level job model, queued at acceptance and popped by an independent output monitor.

module tb_counter_sequencer;

  localparam int NUM_REQ   = 4;
  localparam int BIT_WIDTH = 8;
  localparam int ID_W      = $clog2(NUM_REQ);
  localparam int MAX_CNT   = (1 << BIT_WIDTH) - 1;
  localparam int NO_ABORT  = 1000;

  typedef struct {
    int id;
    int count;
    int err;
    int latency;
    int stamp;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         clk_en;
  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [NUM_REQ-1:0]           req_dir_i;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_seed_i;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_rate_i;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_target_i;
  logic                         abort_i;
  logic                         done_valid_o;
  logic                         done_ready_i;
  logic [ID_W-1:0]              done_id_o;
  logic [BIT_WIDTH-1:0]         done_count_o;
  logic                         done_err_o;
  logic                         busy_o;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   en_edges = 0;
  int   plan [NUM_REQ];
  bit   cur_active = 1'b0;
  int   cur_abort_edge = -1;
  int   last_stamp = -1;

  counter_sequencer #(.NUM_REQ(NUM_REQ), .BIT_WIDTH(BIT_WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_dir_i   (req_dir_i),
    .req_seed_i  (req_seed_i),
    .req_rate_i  (req_rate_i),
    .req_target_i(req_target_i),
    .abort_i     (abort_i),
    .done_valid_o(done_valid_o),
    .done_ready_i(done_ready_i),
    .done_id_o   (done_id_o),
    .done_count_o(done_count_o),
    .done_err_o  (done_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clk_en) en_edges <= en_edges + 1;
  end

  function automatic void checkOutput(string name, int actual, int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  // Walk the job step by step: count after j steps is seed +/- j*rate; stop at the first rule that fires.
  function automatic void model(input int seed, input int rate, input int target, input int dir,
                                input int pl, output int cnt, output int err, output int steps);
    int ab;
    int c;
    ab    = (pl == NO_ABORT) ? -1 : ((pl < 0) ? 0 : pl);
    cnt   = seed;
    err   = 0;
    steps = 0;
    for (int j = 0; j <= MAX_CNT + 2; j++) begin
      c     = (dir != 0) ? seed - j * rate : seed + j * rate;
      cnt   = c;
      steps = j;
      if (j == ab) begin
        err = 1;
        return;
      end
      if ((dir == 0 && c >= target) || (dir != 0 && c <= target)) begin
        err = 0;
        return;
      end
      if (rate == 0 || (dir == 0 && c + rate > MAX_CNT) || (dir != 0 && c < rate)) begin
        err = 1;
        return;
      end
    end
  endfunction

  task automatic applyStimulus(input int r, input int seed, input int rate, input int target,
                               input int dir, input int pl);
    req_seed_i[r*BIT_WIDTH +: BIT_WIDTH]   = BIT_WIDTH'(seed);
    req_rate_i[r*BIT_WIDTH +: BIT_WIDTH]   = BIT_WIDTH'(rate);
    req_target_i[r*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(target);
    req_dir_i[r]   = (dir != 0);
    plan[r]        = pl;
    req_valid_i[r] = 1'b1;
  endtask

  // One clock: note acceptance before the edge, then queue the expected result and steer abort.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    exp_t e;
    int cnt, err, steps;
    @(negedge clk);
    acc = clk_en ? req_ready_o : '0;
    @(posedge clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (acc[r]) begin
        req_valid_i[r] = 1'b0;
        model(int'(req_seed_i[r*BIT_WIDTH +: BIT_WIDTH]), int'(req_rate_i[r*BIT_WIDTH +: BIT_WIDTH]),
              int'(req_target_i[r*BIT_WIDTH +: BIT_WIDTH]), int'(req_dir_i[r]), plan[r],
              cnt, err, steps);
        e.id      = r;
        e.count   = cnt;
        e.err     = err;
        e.latency = steps + 2;
        e.stamp   = en_edges;
        exp_q.push_back(e);
        cur_active     = 1'b1;
        last_stamp     = en_edges;
        cur_abort_edge = (plan[r] == NO_ABORT) ? -1 : en_edges + 1 + plan[r];
      end
    end
    if (cur_active && done_valid_o) begin
      cur_active = 1'b0;
      abort_i    = 1'b0;
    end else if (cur_active && cur_abort_edge >= 0 && en_edges >= cur_abort_edge) begin
      abort_i = 1'b1;
    end
  endtask

  task automatic waitAll(input int budget);
    int n;
    n = 0;
    while (!(req_valid_i == '0 && exp_q.size() == 0 && !busy_o && !done_valid_o) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_in_budget", int'(n < budget), 1);
  endtask

  initial begin : monitor
    int   mptr;
    bit   in_rep;
    bit   hs;
    int   h_id, h_cnt, h_err;
    int   rst_phase, rst_stamp;
    int   g, a;
    exp_t e;
    mptr = 0; in_rep = 0; hs = 0; rst_phase = 0; rst_stamp = 0;
    h_id = 0; h_cnt = 0; h_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        mptr = 0; in_rep = 0; hs = 0; rst_phase = 1;
        checkOutput("rst_ready", int'(req_ready_o), 0);
        checkOutput("rst_done_valid", int'(done_valid_o), 0);
        checkOutput("rst_done_id", int'(done_id_o), 0);
        checkOutput("rst_done_count", int'(done_count_o), 0);
        checkOutput("rst_done_err", int'(done_err_o), 0);
        checkOutput("rst_busy", int'(busy_o), 1);
      end else begin
        if (rst_phase == 1) begin
          rst_stamp = en_edges;
          rst_phase = 2;
        end else if (rst_phase == 2 && !busy_o) begin
          checkOutput("rst_to_idle_edges", en_edges - rst_stamp, 1);
          rst_phase = 0;
        end
        if (busy_o) begin
          checkOutput("ready_when_busy", int'(req_ready_o), 0);
        end else begin
          g = -1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (g < 0 && req_valid_i[(mptr + i) % NUM_REQ]) g = (mptr + i) % NUM_REQ;
          end
          a = -1;
          if ($onehot(req_ready_o)) begin
            for (int i = 0; i < NUM_REQ; i++) if (req_ready_o[i]) a = i;
          end else if (req_ready_o != '0) begin
            a = -2;
          end
          checkOutput("rr_grant", a, g);
          if (clk_en && g >= 0) mptr = (g + 1) % NUM_REQ;
        end
        if (hs) begin
          checkOutput("valid_drop_after_hs", int'(done_valid_o), 0);
          hs = 0;
          in_rep = 0;
        end else if (in_rep) begin
          checkOutput("hold_valid", int'(done_valid_o), 1);
          checkOutput("hold_id", int'(done_id_o), h_id);
          checkOutput("hold_count", int'(done_count_o), h_cnt);
          checkOutput("hold_err", int'(done_err_o), h_err);
        end else if (done_valid_o) begin
          checkOutput("done_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("done_id", int'(done_id_o), e.id);
            checkOutput("done_count", int'(done_count_o), e.count);
            checkOutput("done_err", int'(done_err_o), e.err);
            checkOutput("done_latency", en_edges - e.stamp, e.latency);
          end
          in_rep = 1;
          h_id   = int'(done_id_o);
          h_cnt  = int'(done_count_o);
          h_err  = int'(done_err_o);
        end
        if (in_rep && done_ready_i && clk_en) hs = 1;
      end
    end
  end

  initial begin : stimulus
    int n, r, pl, sel;
    rst          = 1'b1;
    clk_en       = 1'b1;
    req_valid_i  = '0;
    req_dir_i    = '0;
    req_seed_i   = '0;
    req_rate_i   = '0;
    req_target_i = '0;
    abort_i      = 1'b0;
    done_ready_i = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) plan[i] = NO_ABORT;
    repeat (3) tick();
    rst = 1'b0;
    $display("[TB] reset released");

    applyStimulus(1, 10, 5, 30, 0, NO_ABORT);
    waitAll(200);
    applyStimulus(2, 50, 7, 20, 1, NO_ABORT);
    waitAll(200);
    applyStimulus(0, 250, 10, 255, 0, NO_ABORT);
    waitAll(200);
    applyStimulus(3, 3, 5, 0, 1, NO_ABORT);
    waitAll(200);

    // All requesters kept busy, then only 0 and 3.
    for (int t = 0; t < 40; t++) begin
      for (int q = 0; q < NUM_REQ; q++) begin
        if (!req_valid_i[q]) applyStimulus(q, $urandom_range(0, 20), $urandom_range(1, 5),
                                           $urandom_range(0, 30), 0, NO_ABORT);
      end
      tick();
    end
    for (int t = 0; t < 30; t++) begin
      if (!req_valid_i[0]) applyStimulus(0, $urandom_range(0, 20), 2, $urandom_range(0, 30), 0, NO_ABORT);
      if (!req_valid_i[3]) applyStimulus(3, $urandom_range(20, 40), 3, $urandom_range(0, 20), 1, NO_ABORT);
      tick();
    end
    waitAll(500);

    done_ready_i = 1'b0;
    applyStimulus(0, 0, 4, 200, 0, 2);
    n = 0;
    while (!done_valid_o && n < 100) begin
      tick();
      n++;
    end
    checkOutput("abort_done_in_budget", int'(n < 100), 1);
    repeat (5) tick();
    done_ready_i = 1'b1;
    waitAll(100);

    applyStimulus(1, 20, 2, 100, 0, -1);
    waitAll(100);

    applyStimulus(2, 0, 3, 30, 0, NO_ABORT);
    n = 0;
    while (!(req_valid_i == '0 && exp_q.size() == 0 && !busy_o && !done_valid_o) && n < 300) begin
      clk_en = ~clk_en;
      tick();
      n++;
    end
    clk_en = 1'b1;
    checkOutput("gated_drain_in_budget", int'(n < 300), 1);

    last_stamp = -1;
    applyStimulus(0, 0, 4, 200, 0, NO_ABORT);
    n = 0;
    while ((last_stamp < 0 || en_edges < last_stamp + 11) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("reach_count40_in_budget", int'(n < 100), 1);
    #1;
    rst        = 1'b1;
    cur_active = 1'b0;
    abort_i    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    applyStimulus(3, 0, 1, 3, 0, NO_ABORT);
    waitAll(100);

    for (int t = 0; t < 2500; t++) begin
      clk_en       = ($urandom_range(0, 4) != 0);
      done_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, NUM_REQ - 1);
        if (!req_valid_i[r]) begin
          pl  = NO_ABORT;
          sel = $urandom_range(0, 5);
          if (sel == 0) pl = -1;
          else if (sel == 1) pl = $urandom_range(0, 6);
          applyStimulus(r, $urandom_range(0, MAX_CNT), $urandom_range(0, 40),
                        $urandom_range(0, MAX_CNT), $urandom_range(0, 1), pl);
        end
      end
      tick();
    end
    clk_en       = 1'b1;
    done_ready_i = 1'b1;
    waitAll(3000);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
